// File: rtl/split_pkg.sv
// Shared field positions, opcode constants and decoded field bundle for the split stage.
package split_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM16_MSB  = 15;
    localparam int IMM16_LSB  = 0;
    localparam int IMM26_MSB  = 25;
    localparam int IMM26_LSB  = 0;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;

    typedef enum logic [1:0] {
        CLS_R,
        CLS_J,
        CLS_I
    } instr_class_e;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
        logic [5:0]  funct;
        logic [15:0] imm16;
        logic [25:0] imm26;
    } split_fields_t;

    function automatic instr_class_e classify(input logic [5:0] opcode);
        case (opcode)
            OP_RTYPE:    return CLS_R;
            OP_J, OP_JAL: return CLS_J;
            default:     return CLS_I;
        endcase
    endfunction

endpackage

// File: rtl/split_fields.sv
// Combinational MIPS field slicer and R/J/I classifier; class flags are forced low
// when the instruction is not valid.
module split_fields
    import split_pkg::*;
(
    input  logic [31:0]   instr_i,
    input  logic          valid_i,
    output split_fields_t fields_o,
    output logic          is_r_o,
    output logic          is_j_o,
    output logic          is_i_o
);

    instr_class_e cls;

    always_comb begin
        fields_o.opcode = instr_i[OPCODE_MSB:OPCODE_LSB];
        fields_o.rs     = instr_i[RS_MSB:RS_LSB];
        fields_o.rt     = instr_i[RT_MSB:RT_LSB];
        fields_o.rd     = instr_i[RD_MSB:RD_LSB];
        fields_o.shamt  = instr_i[SHAMT_MSB:SHAMT_LSB];
        fields_o.funct  = instr_i[FUNCT_MSB:FUNCT_LSB];
        fields_o.imm16  = instr_i[IMM16_MSB:IMM16_LSB];
        fields_o.imm26  = instr_i[IMM26_MSB:IMM26_LSB];
        cls             = classify(instr_i[OPCODE_MSB:OPCODE_LSB]);
    end

    assign is_r_o = valid_i && (cls == CLS_R);
    assign is_j_o = valid_i && (cls == CLS_J);
    assign is_i_o = valid_i && (cls == CLS_I);

endmodule

// File: rtl/split_stage.sv
// Two-entry skid buffer that splits MIPS instructions into fields. Outputs come from the
// main entry only. Define SPLIT_STAGE_IMM_EXT_EN to add ext_sign / out_imm32.
module split_stage
    import split_pkg::*;
#(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
`ifdef SPLIT_STAGE_IMM_EXT_EN
    input  logic               ext_sign,
    output logic [31:0]        out_imm32,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PC_W-1:0]    out_pc,
    output logic [5:0]         out_opcode,
    output logic [4:0]         out_rs,
    output logic [4:0]         out_rt,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_shamt,
    output logic [5:0]         out_funct,
    output logic [15:0]        out_imm16,
    output logic [25:0]        out_imm26,
    output logic               out_is_r,
    output logic               out_is_j,
    output logic               out_is_i
);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     instr;
`ifdef SPLIT_STAGE_IMM_EXT_EN
        logic            ext;
`endif
    } entry_t;

    entry_t        main_q, main_d, skid_q, skid_d, in_entry;
    logic          main_valid_q, main_valid_d;
    logic          skid_valid_q, skid_valid_d;
    logic          accept, xfer;
    split_fields_t fields;

    always_comb begin
        in_entry       = '0;
        in_entry.pc    = in_pc;
        in_entry.instr = in_instr[31:0];
`ifdef SPLIT_STAGE_IMM_EXT_EN
        in_entry.ext   = ext_sign;
`endif
    end

    assign in_ready = ~skid_valid_q;
    assign accept   = in_valid && in_ready;
    assign xfer     = main_valid_q && out_ready;

    always_comb begin
        main_valid_d = main_valid_q;
        skid_valid_d = skid_valid_q;
        main_d       = main_q;
        skid_d       = skid_q;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q || xfer) begin
            // Main frees up: a pending skid entry goes first to keep order.
            if (skid_valid_q) begin
                main_valid_d = 1'b1;
                main_d       = skid_q;
                skid_valid_d = accept;
                if (accept) begin
                    skid_d = in_entry;
                end
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_d = in_entry;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = in_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            main_q       <= main_d;
            skid_q       <= skid_d;
        end
    end

    split_fields u_fields (
        .instr_i  (main_q.instr),
        .valid_i  (main_valid_q),
        .fields_o (fields),
        .is_r_o   (out_is_r),
        .is_j_o   (out_is_j),
        .is_i_o   (out_is_i)
    );

    assign out_valid  = main_valid_q;
    assign out_pc     = main_q.pc;
    assign out_opcode = fields.opcode;
    assign out_rs     = fields.rs;
    assign out_rt     = fields.rt;
    assign out_rd     = fields.rd;
    assign out_shamt  = fields.shamt;
    assign out_funct  = fields.funct;
    assign out_imm16  = fields.imm16;
    assign out_imm26  = fields.imm26;

`ifdef SPLIT_STAGE_IMM_EXT_EN
    assign out_imm32 = {{16{fields.imm16[15] & main_q.ext}}, fields.imm16};
`endif

endmodule

// File: tb/tb_split_stage.sv
// Directed bench for split_stage: table of decode vectors plus skid, flush and reset
// sequences; also covers out_imm32 when SPLIT_STAGE_IMM_EXT_EN is defined.
module tb_split_stage;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               flush = 1'b0;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic [INSTR_W-1:0] in_instr = '0;
    logic [PC_W-1:0]    in_pc = '0;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [PC_W-1:0]    out_pc;
    logic [5:0]         out_opcode;
    logic [4:0]         out_rs, out_rt, out_rd, out_shamt;
    logic [5:0]         out_funct;
    logic [15:0]        out_imm16;
    logic [25:0]        out_imm26;
    logic               out_is_r, out_is_j, out_is_i;
`ifdef SPLIT_STAGE_IMM_EXT_EN
    logic               ext_sign = 1'b0;
    logic [31:0]        out_imm32;
`endif

    int tests = 0;
    int fails = 0;

    split_stage #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_instr   (in_instr),
        .in_pc      (in_pc),
`ifdef SPLIT_STAGE_IMM_EXT_EN
        .ext_sign   (ext_sign),
        .out_imm32  (out_imm32),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_pc     (out_pc),
        .out_opcode (out_opcode),
        .out_rs     (out_rs),
        .out_rt     (out_rt),
        .out_rd     (out_rd),
        .out_shamt  (out_shamt),
        .out_funct  (out_funct),
        .out_imm16  (out_imm16),
        .out_imm26  (out_imm26),
        .out_is_r   (out_is_r),
        .out_is_j   (out_is_j),
        .out_is_i   (out_is_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [73:0] exp_fields;
        logic [2:0]  exp_cls;   // {is_r, is_j, is_i}
    } vec_t;

    vec_t vecs[6];

    function automatic logic [73:0] pack(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] rd,
                                         input logic [4:0] sh, input logic [5:0] fn,
                                         input logic [15:0] i16, input logic [25:0] i26);
        return {op, rs, rt, rd, sh, fn, i16, i26};
    endfunction

    function automatic logic [73:0] dut_fields();
        return {out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct, out_imm16, out_imm26};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] got_pcs[$];
    logic [31:0] exp_pcs[3];
    bit          c_taken;
    int          seen;

    initial begin
        vecs[0] = '{32'h012A4020, 32'h0000_3000, pack(6'h00, 5'd9, 5'd10, 5'd8, 5'd0, 6'h20, 16'h4020, 26'h12A4020), 3'b100};
        vecs[1] = '{32'h0C000C00, 32'h0000_3004, pack(6'h03, 5'd0, 5'd0, 5'd1, 5'd16, 6'h00, 16'h0C00, 26'h0000C00), 3'b010};
        vecs[2] = '{32'h3C011234, 32'h0000_3008, pack(6'h0F, 5'd0, 5'd1, 5'd2, 5'd8, 6'h34, 16'h1234, 26'h0011234), 3'b001};
        vecs[3] = '{32'h08000004, 32'h0000_300C, pack(6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'h04, 16'h0004, 26'h0000004), 3'b010};
        vecs[4] = '{32'hFFFFFFFF, 32'hFFFF_FFFC, pack(6'h3F, 5'd31, 5'd31, 5'd31, 5'd31, 6'h3F, 16'hFFFF, 26'h3FFFFFF), 3'b001};
        vecs[5] = '{32'h00000000, 32'h0000_0010, pack(6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000000), 3'b100};

        // Reset state
        #3;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_fields", dut_fields(), 74'd0);
        check("rst_pc", out_pc, 32'd0);
        check("rst_cls", {out_is_r, out_is_j, out_is_i}, 3'b000);
        @(negedge clk);
        reset = 1'b1;
        tick();

        // Decode table, streaming with out_ready high
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            in_pc    = vecs[i].pc;
            tick();
            in_valid = 1'b0;
            check($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            check($sformatf("vec%0d_fields", i), dut_fields(), vecs[i].exp_fields);
            check($sformatf("vec%0d_cls", i), {out_is_r, out_is_j, out_is_i}, vecs[i].exp_cls);
            check($sformatf("vec%0d_pc", i), out_pc, vecs[i].pc);
            $display("[TB] vec %0d instr %h pc %h -> op %h cls %b", i, vecs[i].instr, out_pc,
                     out_opcode, {out_is_r, out_is_j, out_is_i});
        end
        tick();
        check("idle_valid", out_valid, 1'b0);
        check("idle_cls", {out_is_r, out_is_j, out_is_i}, 3'b000);

        // Back-to-back with downstream stalled, then drain in order
        out_ready = 1'b0;
        exp_pcs = '{32'h100, 32'h104, 32'h108};
        in_valid = 1'b1; in_instr = 32'h012A4020; in_pc = exp_pcs[0];
        tick();
        check("stall1_in_ready", in_ready, 1'b1);
        in_instr = 32'h3C011234; in_pc = exp_pcs[1];
        tick();
        check("stall2_in_ready", in_ready, 1'b0);
        in_instr = 32'h0C000C00; in_pc = exp_pcs[2];
        tick();
        check("stall3_in_ready", in_ready, 1'b0);
        check("stall3_pc", out_pc, exp_pcs[0]);
        check("stall3_fields", dut_fields(), vecs[0].exp_fields);
        tick();
        check("stall4_pc_stable", out_pc, exp_pcs[0]);
        check("stall4_fields_stable", dut_fields(), vecs[0].exp_fields);
        $display("[TB] stall: main pc %h held, in_ready %b", out_pc, in_ready);
        out_ready = 1'b1;
        c_taken = 1'b0;
        got_pcs.delete();
        for (int cyc = 0; cyc < 10; cyc++) begin
            if (out_valid) got_pcs.push_back(out_pc);
            if (in_valid && in_ready) c_taken = 1'b1;
            tick();
            if (c_taken) in_valid = 1'b0;
        end
        check("drain_count", got_pcs.size(), 3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_pcs.size()) begin
                check($sformatf("drain%0d_pc", i), got_pcs[i], exp_pcs[i]);
                $display("[TB] drain %0d pc %h", i, got_pcs[i]);
            end
        end

        // Flush with both entries full and a same-cycle offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h012A4020; in_pc = 32'h200;
        tick();
        in_pc = 32'h204;
        tick();
        check("flush_pre_full", in_ready, 1'b0);
        flush = 1'b1; in_pc = 32'h208; in_instr = 32'h08000004;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_cls", {out_is_r, out_is_j, out_is_i}, 3'b000);
        out_ready = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            if (out_valid) seen++;
            tick();
        end
        check("flush_nothing_after", seen, 0);
        $display("[TB] flush: %0d entries seen after flush", seen);

        // Asynchronous reset mid-cycle with main valid
        out_ready = 1'b0;
        in_valid = 1'b1; in_instr = 32'h3C011234; in_pc = 32'h300;
        tick();
        in_valid = 1'b0;
        check("areset_pre_valid", out_valid, 1'b1);
        #2 reset = 1'b0;
        #1;
        check("areset_out_valid", out_valid, 1'b0);
        check("areset_pc", out_pc, 32'd0);
        check("areset_fields", dut_fields(), 74'd0);
        check("areset_in_ready", in_ready, 1'b1);
        #2 reset = 1'b1;
        tick();
        in_valid = 1'b1; in_instr = 32'h0C000C00; in_pc = 32'h304;
        tick();
        in_valid = 1'b0;
        check("post_reset_valid", out_valid, 1'b1);
        check("post_reset_pc", out_pc, 32'h304);
        check("post_reset_in_ready", in_ready, 1'b1);
        $display("[TB] async reset: out_pc %h after release", out_pc);

`ifdef SPLIT_STAGE_IMM_EXT_EN
        out_ready = 1'b1;
        tick();
        in_valid = 1'b1; in_instr = 32'h2008FFFF; ext_sign = 1'b1; in_pc = 32'h400;
        tick();
        check("imm32_sext_neg", out_imm32, 32'hFFFFFFFF);
        in_instr = 32'h3408FFFF; ext_sign = 1'b0;
        tick();
        check("imm32_zext", out_imm32, 32'h0000FFFF);
        in_instr = 32'h20080001; ext_sign = 1'b1;
        tick();
        in_valid = 1'b0;
        check("imm32_sext_pos", out_imm32, 32'h00000001);
        $display("[TB] imm32 ext: last %h", out_imm32);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
